// File: rtl/count_mon_pkg.sv
// Shared constants for the counter window monitor: state encodings and default widths.
package count_mon_pkg;
  localparam int unsigned DEFAULT_W  = 8;
  localparam int unsigned DEFAULT_DW = 4;

  localparam logic [DEFAULT_W-1:0] CNT_MAX = {DEFAULT_W{1'b1}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;
endpackage

// File: rtl/wrap_detector.sv
// Detects 255->0 (up) and 0->255 (down) wraps between consecutive samples of the counter.
module wrap_detector
  import count_mon_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_en,
  input  logic [W-1:0] cnt_in,
  input  logic         mode_in,
  output logic         wrap_up_c,
  output logic         wrap_dn_c,
  output logic         wrap_up,
  output logic         wrap_dn
);
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] prev;
  logic         prev_valid;

  // Combinational detect feeds the hi-byte update in the same cycle as the registered pulse.
  assign wrap_up_c = sample_en && prev_valid && (prev == MAX) && (cnt_in == '0) && mode_in;
  assign wrap_dn_c = sample_en && prev_valid && (prev == '0) && (cnt_in == MAX) && !mode_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
    end else begin
      wrap_up <= wrap_up_c;
      wrap_dn <= wrap_dn_c;
      if (sample_en) begin
        prev       <= cnt_in;
        prev_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/count_window_monitor.sv
// Samples an up/down counter, extends it with a wrap byte, and latches an alarm after
// the value dwells inside a programmable window for a number of consecutive samples.
module count_window_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned W  = DEFAULT_W,
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sample_en,
  input  logic [W-1:0]   cnt_in,
  input  logic           mode_in,
  input  logic [W-1:0]   win_lo,
  input  logic [W-1:0]   win_hi,
  input  logic [DW-1:0]  dwell,
  input  logic           alarm_clr,
  output logic           wrap_up,
  output logic           wrap_dn,
  output logic [2*W-1:0] ext_count,
  output logic           in_window,
  output logic           alarm,
  output logic [1:0]     state
);
  localparam logic [DW-1:0] RUN_MAX = {DW{1'b1}};

  logic          wrap_up_c, wrap_dn_c;
  logic          in_win_c, eval_c;
  logic [DW-1:0] dwell_eff, run, run_base, run_next;
  logic [W-1:0]  hi, lo, hi_d, lo_d;
  logic [DW-1:0] run_d;
  logic [1:0]    state_d;
  logic          alarm_d, in_win_d;

  wrap_detector #(.W(W)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .cnt_in    (cnt_in),
    .mode_in   (mode_in),
    .wrap_up_c (wrap_up_c),
    .wrap_dn_c (wrap_dn_c),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn)
  );

  assign in_win_c  = (cnt_in >= win_lo) && (cnt_in <= win_hi);
  assign dwell_eff = (dwell == '0) ? DW'(1) : dwell;
  assign ext_count = {hi, lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alarm     <= 1'b0;
      run       <= '0;
      hi        <= '0;
      lo        <= '0;
      in_window <= 1'b0;
    end else begin
      state     <= state_d;
      alarm     <= alarm_d;
      run       <= run_d;
      hi        <= hi_d;
      lo        <= lo_d;
      in_window <= in_win_d;
    end
  end

  // A clear in ALARM restarts the run, so a coincident sample is scored from zero.
  always_comb begin
    state_d  = state;
    alarm_d  = alarm;
    run_d    = run;
    hi_d     = hi;
    lo_d     = lo;
    in_win_d = in_window;
    run_base = (state == ST_TRACK) ? run : '0;
    run_next = !in_win_c ? '0 : ((run_base == RUN_MAX) ? RUN_MAX : run_base + DW'(1));
    eval_c   = 1'b0;

    if (sample_en) begin
      lo_d     = cnt_in;
      in_win_d = in_win_c;
      if (wrap_up_c)      hi_d = hi + W'(1);
      else if (wrap_dn_c) hi_d = hi - W'(1);
    end

    case (state)
      ST_IDLE, ST_TRACK: eval_c = sample_en;
      ST_ALARM: begin
        if (alarm_clr) begin
          eval_c = sample_en;
          if (!sample_en) begin
            state_d = ST_TRACK;
            alarm_d = 1'b0;
            run_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        alarm_d = 1'b0;
        run_d   = '0;
      end
    endcase

    if (eval_c) begin
      run_d = run_next;
      if (run_next >= dwell_eff) begin
        state_d = ST_ALARM;
        alarm_d = 1'b1;
      end else begin
        state_d = ST_TRACK;
        alarm_d = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_count_window_monitor.sv
// Directed bench for count_window_monitor: reset, wraps, dwell alarm, clear collision, empty window.
module tb_count_window_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [7:0]  cnt_in;
  logic        mode_in;
  logic [7:0]  win_lo, win_hi;
  logic [3:0]  dwell;
  logic        alarm_clr;
  logic        wrap_up, wrap_dn;
  logic [15:0] ext_count;
  logic        in_window, alarm;
  logic [1:0]  state;

  int n_pass  = 0;
  int n_total = 0;

  count_window_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .cnt_in    (cnt_in),
    .mode_in   (mode_in),
    .win_lo    (win_lo),
    .win_hi    (win_hi),
    .dwell     (dwell),
    .alarm_clr (alarm_clr),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .ext_count (ext_count),
    .in_window (in_window),
    .alarm     (alarm),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one sample cycle; returns at the next negedge with outputs settled.
  task automatic smp(input logic [7:0] c, input logic m, input logic clr);
    @(negedge clk);
    sample_en = 1'b1; cnt_in = c; mode_in = m; alarm_clr = clr;
    @(negedge clk);
    sample_en = 1'b0; alarm_clr = 1'b0;
  endtask

  task automatic idle_cycle(input logic clr);
    @(negedge clk);
    alarm_clr = clr;
    @(negedge clk);
    alarm_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] dv [6];
  logic [3:0] drun [6];
  logic       dalm [6];
  logic       dwin [6];
  int         hits;

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; cnt_in = '0; mode_in = 1'b1;
    win_lo = 8'd1; win_hi = 8'd0; dwell = 4'd3; alarm_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ext", 32'(ext_count), 32'h0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_flags", 32'({wrap_up, wrap_dn, in_window, alarm}), 32'h0);
    rst_n = 1'b1;

    // Build run=2, alarm=1, hi=3 then reset asynchronously mid-cycle
    win_lo = 8'h00; win_hi = 8'hFF; dwell = 4'd2;
    for (int i = 0; i < 3; i++) begin
      smp(8'hFF, 1'b1, 1'b0);
      smp(8'h00, 1'b1, 1'b0);
    end
    check("pre_rst_ext", 32'(ext_count), 32'h0300);
    check("pre_rst_alarm", 32'({alarm, state}), 32'b1_10);
    check("pre_rst_run", 32'(dut.run), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ext", 32'(ext_count), 32'h0);
    check("async_rst_alarm_state", 32'({alarm, in_window, state}), 32'h0);
    check("async_rst_run", 32'(dut.run), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    smp(8'hFF, 1'b0, 1'b0);
    check("post_rst_no_wrap", 32'({wrap_up, wrap_dn}), 32'h0);
    check("post_rst_ext", 32'(ext_count), 32'h00FF);

    // Up wrap
    win_lo = 8'd1; win_hi = 8'd0;
    do_reset();
    smp(8'hFE, 1'b1, 1'b0);
    check("up_fe", 32'(wrap_up), 32'd0);
    smp(8'hFF, 1'b1, 1'b0);
    check("up_ff", 32'(wrap_up), 32'd0);
    smp(8'h00, 1'b1, 1'b0);
    check("up_00", 32'({wrap_up, wrap_dn}), 32'b10);
    check("up_ext", 32'(ext_count), 32'h0100);
    idle_cycle(1'b0);
    check("up_pulse_once", 32'(wrap_up), 32'd0);
    for (int i = 0; i < 255; i++) begin
      smp(8'hFF, 1'b1, 1'b0);
      smp(8'h00, 1'b1, 1'b0);
    end
    check("up_255_more", 32'(ext_count), 32'h0000);
    smp(8'hFF, 1'b1, 1'b0);
    smp(8'h00, 1'b1, 1'b0);
    check("up_257_total", 32'(ext_count), 32'h0100);

    // Down wrap, and direction mismatch
    do_reset();
    smp(8'h00, 1'b0, 1'b0);
    check("dn_00", 32'(wrap_dn), 32'd0);
    smp(8'hFF, 1'b0, 1'b0);
    check("dn_ff", 32'({wrap_up, wrap_dn}), 32'b01);
    check("dn_ext", 32'(ext_count), 32'hFFFF);
    do_reset();
    smp(8'h00, 1'b1, 1'b0);
    smp(8'hFF, 1'b1, 1'b0);
    check("dn_mismatch", 32'({wrap_up, wrap_dn}), 32'h0);
    check("dn_mismatch_ext", 32'(ext_count), 32'h00FF);

    // Dwell run
    do_reset();
    win_lo = 8'd10; win_hi = 8'd20; dwell = 4'd3;
    dv   = '{8'd12, 8'd13, 8'd25, 8'd14, 8'd15, 8'd16};
    drun = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3};
    dalm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dwin = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      smp(dv[i], 1'b1, 1'b0);
      check($sformatf("dwell_run%0d", i), 32'(dut.run), 32'(drun[i]));
      check($sformatf("dwell_alarm%0d", i), 32'(alarm), 32'(dalm[i]));
      check($sformatf("dwell_win%0d", i), 32'(in_window), 32'(dwin[i]));
    end
    check("dwell_state", 32'(state), 32'd2);
    check("dwell_ext_lo", 32'(ext_count), 32'h0010);

    // Clear and sample together
    dwell = 4'd1;
    smp(8'd15, 1'b1, 1'b1);
    check("coll_d1", 32'({alarm, state}), 32'b1_10);
    check("coll_d1_run", 32'(dut.run), 32'd1);
    dwell = 4'd2;
    smp(8'd15, 1'b1, 1'b1);
    check("coll_d2", 32'({alarm, state}), 32'b0_01);
    check("coll_d2_run", 32'(dut.run), 32'd1);
    idle_cycle(1'b1);
    check("clr_in_track", 32'({alarm, state}), 32'b0_01);
    smp(8'd11, 1'b1, 1'b0);
    check("realarm_d2", 32'({alarm, state}), 32'b1_10);

    // dwell=0 behaves as 1; clear alone returns to TRACK
    do_reset();
    dwell = 4'd0;
    smp(8'd12, 1'b1, 1'b0);
    check("dwell0_alarm", 32'({alarm, state}), 32'b1_10);
    smp(8'd30, 1'b1, 1'b0);
    check("alarm_hold", 32'({alarm, in_window, state}), 32'b1_0_10);
    idle_cycle(1'b1);
    check("clr_only", 32'({alarm, state}), 32'b0_01);
    check("clr_only_run", 32'(dut.run), 32'd0);

    // Empty window sweep
    do_reset();
    win_lo = 8'd30; win_hi = 8'd5; dwell = 4'd1;
    hits = 0;
    for (int v = 0; v < 256; v++) begin
      smp(8'(v), 1'b1, 1'b0);
      if (in_window || alarm) hits++;
    end
    check("empty_window_hits", 32'(hits), 32'd0);
    check("empty_window_state", 32'(state), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
